background_plotter: RTL and testbench
=====================================

Name: background_plotter

Overview:
- Downstream neighbour of the background address counter: a start-triggered frame painter.
- Scans the full 160x120 background frame once per start and issues linear addresses to the synchronous background ROM.
- Re-aligns the ROM output with its coordinates through a delay pipeline and drives x/y/colour/plot to the VGA adapter.
- Signals completion to the top-level game FSM.

Parameters:
X_SCREEN_PIXELS, 160, frame width in pixels
Y_SCREEN_PIXELS, 120, frame height in pixels
COLOR_WIDTH, 3, colour bits per pixel
ROM_LATENCY, 1, cycles from ROM address sampled to q valid; legal values 1 or 2

Ports:
iClock  input  1  system clock, all logic on rising edge
iResetn  input  1  synchronous active-low reset
iStart  input  1  level; sampled only in IDLE, begins one frame paint
oRomAddr  output  15  linear ROM address, y*160+x, registered
iRomQ  input  COLOR_WIDTH  ROM read data, valid ROM_LATENCY edges after address sampled
oX  output  8  pixel x to VGA adapter
oY  output  7  pixel y to VGA adapter
oColour  output  COLOR_WIDTH  pixel colour to VGA adapter
oPlot  output  1  write strobe, one pixel per high cycle
oBusy  output  1  high from leaving IDLE until oDone cycle inclusive
oDone  output  1  one-cycle pulse after last pixel plotted

Behaviour:
- Clock and reset: one clock, iClock. Reset is synchronous, active-low, on iResetn.
- Reset values: all outputs 0; state IDLE; pipeline valid bits cleared.
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE: edge E0 with iStart=1 moves to SCAN.
  - x=y=0, oRomAddr=0, oBusy=1.
- SCAN: each edge advances the scan by one pixel.
  - x increments; at x=X_SCREEN_PIXELS-1, x wraps to 0 and y increments.
  - oRomAddr increments by 1 every edge. It is an incremental counter, not a multiplier.
  - After the edge that issues (159,119)/addr 19199, go to DRAIN.
- Pipeline: each issued address pushes {x,y,valid=1} into a ROM_LATENCY+1 deep shift register.
  - Outputs are registered from the pipeline tail plus iRomQ.
  - First oPlot is high in the cycle after edge E(ROM_LATENCY+1).
  - oPlot is high for exactly 19200 consecutive cycles, with no gaps.
- DRAIN: waits until the pipeline is empty. The last oPlot shows (159,119) and the colour of addr 19199.
- DONE: oDone=1 for exactly one cycle, immediately after the last oPlot cycle. Next edge goes to IDLE and oBusy=0.
- iStart in any state other than IDLE is ignored. Holding iStart high continuously repaints back-to-back with one IDLE cycle between frames.
- oX/oY/oColour hold their last values while oPlot=0. The VGA adapter must only qualify them with oPlot.
- Reset mid-frame: next cycle is IDLE, all outputs 0, no oDone, pipeline flushed. A stale iRomQ is never plotted.
- Width rules:
  - oRomAddr is 15 bits, maximum 19199. It never reaches 19200 inside SCAN and is reset to 0 on leaving IDLE.
  - x compares against X_SCREEN_PIXELS-1 at 8 bits; y against Y_SCREEN_PIXELS-1 at 7 bits.

Decomposition:
- Shared package (screen_pkg): X_SCREEN_PIXELS, Y_SCREEN_PIXELS, COLOR_WIDTH, FRAME_PIXELS=19200, ADDR_WIDTH=15, and the plotter state encoding.
- Sub-module xy_scan_counter:
  - Inputs: clock, reset, enable.
  - Outputs: x, y, linear addr, last flag.
  - Gives a single-cycle wrap.
  - Reusable by sprite plotters.
- The top holds the FSM, the alignment pipeline and the output registers.

Test Plan:
- Reset, iStart=1 one cycle, ROM model q=addr[2:0] with ROM_LATENCY=1:
  - First oPlot 2 cycles after the start edge with (0,0,colour 0).
  - Next pixels are (1,0,1) and (2,0,2).
- Row wrap: the pixel after (159,0) is (0,1), colour (160 mod 8)=0; oRomAddr goes 159 -> 160 on consecutive edges.
- End of frame:
  - Exactly 19200 oPlot cycles; last is (159,119) with colour 19199 mod 8=7.
  - oDone high exactly 1 cycle after that; oBusy falls the cycle after oDone.
- iStart pulsed again mid-SCAN at pixel 5000: no restart, total plots still 19200, single oDone.
- iResetn=0 for 1 cycle at pixel 8000:
  - All outputs 0 next cycle, no oDone, no further oPlot until a new iStart.
  - The new frame starts at (0,0).
- ROM_LATENCY=2, iStart held high for two frames:
  - First oPlot 3 cycles after the start edge, colours aligned to coordinates.
  - Two oDone pulses, with 19200 plots per frame.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared screen geometry, address widths and plotter state encoding
// for the background and sprite plotting datapaths.
package screen_pkg;

   localparam int X_SCREEN_PIXELS = 160;
   localparam int Y_SCREEN_PIXELS = 120;
   localparam int COLOR_WIDTH     = 3;
   localparam int FRAME_PIXELS    = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
   localparam int ADDR_WIDTH      = 15;
   localparam int X_WIDTH         = 8;
   localparam int Y_WIDTH         = 7;

   localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(X_SCREEN_PIXELS - 1);
   localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(Y_SCREEN_PIXELS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DRAIN,
      S_DONE
   } plot_state_e;

   typedef struct packed {
      logic               valid;
      logic [X_WIDTH-1:0] x;
      logic [Y_WIDTH-1:0] y;
   } pix_tag_t;

endpackage

// File: rtl/background_plotter_if.sv
// Scan bus between an x/y raster counter and the plotter that owns it.
interface background_plotter_if;
   import screen_pkg::*;

   logic                  en;
   logic [X_WIDTH-1:0]    x;
   logic [Y_WIDTH-1:0]    y;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  last;

   modport master (input en, output x, y, addr, last);
   modport slave  (output en, input x, y, addr, last);

endinterface

// File: rtl/xy_scan_counter.sv
// Raster counter: x/y plus a linear address kept as its own incrementer,
// wrapping to the origin in the same cycle it passes the last pixel.
module xy_scan_counter
   import screen_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   background_plotter_if.master scan
);

   logic [X_WIDTH-1:0]    x_q, x_d;
   logic [Y_WIDTH-1:0]    y_q, y_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  x_end, y_end;

   assign x_end = (x_q == X_LAST);
   assign y_end = (y_q == Y_LAST);

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      addr_d = addr_q;
      if (scan.en) begin
         if (x_end) begin
            x_d = '0;
            y_d = y_end ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
         addr_d = (x_end && y_end) ? '0 : addr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         x_q    <= '0;
         y_q    <= '0;
         addr_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         addr_q <= addr_d;
      end
   end

   assign scan.x    = x_q;
   assign scan.y    = y_q;
   assign scan.addr = addr_q;
   assign scan.last = x_end && y_end;

endmodule

// File: rtl/background_plotter.sv
// Start-triggered background painter: scans the frame into the ROM and
// re-aligns ROM data with its coordinates before driving the VGA adapter.
module background_plotter
   import screen_pkg::*;
#(
   parameter int ROM_LATENCY = 1
) (
   input  logic                   iClock,
   input  logic                   iResetn,
   input  logic                   iStart,
   output logic [ADDR_WIDTH-1:0]  oRomAddr,
   input  logic [COLOR_WIDTH-1:0] iRomQ,
   output logic [X_WIDTH-1:0]     oX,
   output logic [Y_WIDTH-1:0]     oY,
   output logic [COLOR_WIDTH-1:0] oColour,
   output logic                   oPlot,
   output logic                   oBusy,
   output logic                   oDone
);

   background_plotter_if scan ();

   xy_scan_counter u_scan (
      .clk_i  (iClock),
      .rst_ni (iResetn),
      .scan   (scan)
   );

   plot_state_e            state_q;
   pix_tag_t               pipe_q [ROM_LATENCY];
   pix_tag_t               head;
   logic                   pipe_busy;
   logic [X_WIDTH-1:0]     x_q;
   logic [Y_WIDTH-1:0]     y_q;
   logic [COLOR_WIDTH-1:0] colour_q;
   logic                   plot_q, busy_q, done_q;

   assign scan.en = (state_q == S_SCAN);

   // Counter output is the address on the ROM bus, i.e. pipeline stage 0
   assign head = '{valid: (state_q == S_SCAN), x: scan.x, y: scan.y};

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
         pipe_busy = pipe_busy | pipe_q[i].valid;
      end
   end

   always_ff @(posedge iClock) begin
      if (!iResetn) begin
         state_q  <= S_IDLE;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         pipe_q[0] <= head;
         for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
         plot_q <= pipe_q[ROM_LATENCY-1].valid;
         if (pipe_q[ROM_LATENCY-1].valid) begin
            x_q      <= pipe_q[ROM_LATENCY-1].x;
            y_q      <= pipe_q[ROM_LATENCY-1].y;
            colour_q <= iRomQ;
         end
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (iStart) begin
                  state_q <= S_SCAN;
                  busy_q  <= 1'b1;
               end
            end
            S_SCAN: begin
               if (scan.last) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!pipe_busy) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign oRomAddr = scan.addr;
   assign oX       = x_q;
   assign oY       = y_q;
   assign oColour  = colour_q;
   assign oPlot    = plot_q;
   assign oBusy    = busy_q;
   assign oDone    = done_q;

endmodule

// File: tb/tb_background_plotter.sv
// Directed bench: two plotters (ROM latency 1 and 2) fed by ROM models
// returning addr[2:0], with hand-derived pixel, timing and pulse checks.
module tb_background_plotter;
   import screen_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total_cnt = 0;

   logic        rst1_n, start1;
   logic [14:0] a1;
   logic [2:0]  q1;
   logic [7:0]  x1;
   logic [6:0]  y1;
   logic [2:0]  c1;
   logic        plot1, busy1, done1;

   background_plotter #(.ROM_LATENCY(1)) dut1 (
      .iClock(clk), .iResetn(rst1_n), .iStart(start1),
      .oRomAddr(a1), .iRomQ(q1),
      .oX(x1), .oY(y1), .oColour(c1),
      .oPlot(plot1), .oBusy(busy1), .oDone(done1)
   );

   always_ff @(posedge clk) q1 <= a1[2:0];

   logic        rst2_n, start2;
   logic [14:0] a2;
   logic [2:0]  q2a, q2;
   logic [7:0]  x2;
   logic [6:0]  y2;
   logic [2:0]  c2;
   logic        plot2, busy2, done2;

   background_plotter #(.ROM_LATENCY(2)) dut2 (
      .iClock(clk), .iResetn(rst2_n), .iStart(start2),
      .oRomAddr(a2), .iRomQ(q2),
      .oX(x2), .oY(y2), .oColour(c2),
      .oPlot(plot2), .oBusy(busy2), .oDone(done2)
   );

   always_ff @(posedge clk) begin
      q2a <= a2[2:0];
      q2  <= q2a;
   end

   // Probe bundle on the latency-1 pixel bus
   background_plotter_if mon ();
   assign mon.en   = plot1;
   assign mon.x    = x1;
   assign mon.y    = y1;
   assign mon.addr = a1;
   assign mon.last = done1;

   int          w_plots, w_seqerr, w_gaps, w_dones, w_done_adj;
   int          w_busy_at_done, w_busy_after, w_prev160;
   logic [17:0] w_last, w_px159, w_px160;

   task automatic watch1(input int already, input int pulse_at, input int budget);
      int   prev_addr, idx, after;
      logic prev_plot;
      w_plots = already; w_seqerr = 0; w_gaps = 0; w_dones = 0;
      w_done_adj = 0; w_busy_at_done = -1; w_busy_after = -1; w_prev160 = -1;
      w_last = '1; w_px159 = '1; w_px160 = '1;
      prev_plot = (already > 0);
      prev_addr = int'(mon.addr);
      after = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (mon.addr == 15'd160 && w_prev160 < 0) w_prev160 = prev_addr;
         if (mon.en) begin
            if (!prev_plot && w_plots > 0) w_gaps++;
            idx = w_plots;
            if ({mon.x, mon.y, c1} !== {8'(idx % 160), 7'(idx / 160), 3'(idx % 8)})
               w_seqerr++;
            if (idx == 159) w_px159 = {mon.x, mon.y, c1};
            if (idx == 160) w_px160 = {mon.x, mon.y, c1};
            w_last = {mon.x, mon.y, c1};
            w_plots++;
            if (w_plots == pulse_at) start1 = 1'b1;
         end
         if (mon.last) begin
            w_dones++;
            if (prev_plot && !mon.en) w_done_adj++;
            w_busy_at_done = int'(busy1);
         end else if (w_dones > 0 && after < 0) begin
            w_busy_after = int'(busy1);
            after = n;
         end
         if (after >= 0 && n >= after + 3) break;
         prev_plot = mon.en;
         prev_addr = int'(mon.addr);
      end
   endtask

   task automatic test_reset();
      rst1_n = 1'b0; start1 = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++;
      if ({a1, plot1, busy1, done1} !== 18'd0)
         $display("FAIL reset_ctrl got addr=%0d plot=%b busy=%b done=%b want 0", a1, plot1, busy1, done1);
      else pass_cnt++;
      total_cnt++;
      if ({x1, y1, c1} !== 18'd0)
         $display("FAIL reset_pix got (%0d,%0d,%0d) want (0,0,0)", x1, y1, c1);
      else pass_cnt++;
      rst1_n = 1'b1;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({plot1, busy1, done1} !== 3'b000)
         $display("FAIL idle_no_start got plot=%b busy=%b done=%b want 000", plot1, busy1, done1);
      else pass_cnt++;
   endtask

   task automatic test_first_pixels();
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      total_cnt++;
      if ({busy1, a1, plot1} !== {1'b1, 15'd0, 1'b0})
         $display("FAIL e0_state got busy=%b addr=%0d plot=%b want 1,0,0", busy1, a1, plot1);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({a1, plot1} !== {15'd1, 1'b0})
         $display("FAIL e1_state got addr=%0d plot=%b want 1,0", a1, plot1);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({plot1, x1, y1, c1} !== {1'b1, 8'd0, 7'd0, 3'd0})
         $display("FAIL first_pix got plot=%b (%0d,%0d,%0d) want 1 (0,0,0)", plot1, x1, y1, c1);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({plot1, x1, y1, c1, a1} !== {1'b1, 8'd1, 7'd0, 3'd1, 15'd3})
         $display("FAIL pix1 got plot=%b (%0d,%0d,%0d) addr=%0d want 1 (1,0,1) 3", plot1, x1, y1, c1, a1);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({plot1, x1, y1, c1} !== {1'b1, 8'd2, 7'd0, 3'd2})
         $display("FAIL pix2 got plot=%b (%0d,%0d,%0d) want 1 (2,0,2)", plot1, x1, y1, c1);
      else pass_cnt++;
      watch1(3, -1, 19300);
   endtask

   task automatic test_row_wrap();
      total_cnt++;
      if (w_px159 !== {8'd159, 7'd0, 3'd7})
         $display("FAIL pix159 got %h want %h", w_px159, {8'd159, 7'd0, 3'd7});
      else pass_cnt++;
      total_cnt++;
      if (w_px160 !== {8'd0, 7'd1, 3'd0})
         $display("FAIL row_wrap got %h want %h", w_px160, {8'd0, 7'd1, 3'd0});
      else pass_cnt++;
      total_cnt++;
      if (w_prev160 != 159)
         $display("FAIL addr_before_160 got %0d want 159", w_prev160);
      else pass_cnt++;
   endtask

   task automatic test_frame_end();
      total_cnt++;
      if (w_plots != 19200) $display("FAIL plot_count got %0d want 19200", w_plots);
      else pass_cnt++;
      total_cnt++;
      if (w_seqerr != 0 || w_gaps != 0)
         $display("FAIL pix_sequence got seqerr=%0d gaps=%0d want 0,0", w_seqerr, w_gaps);
      else pass_cnt++;
      total_cnt++;
      if (w_last !== {8'd159, 7'd119, 3'd7})
         $display("FAIL last_pix got %h want %h", w_last, {8'd159, 7'd119, 3'd7});
      else pass_cnt++;
      total_cnt++;
      if (w_dones != 1 || w_done_adj != 1)
         $display("FAIL done_pulse got count=%0d adjacent=%0d want 1,1", w_dones, w_done_adj);
      else pass_cnt++;
      total_cnt++;
      if (w_busy_at_done != 1 || w_busy_after != 0)
         $display("FAIL busy_fall got at_done=%0d after=%0d want 1,0", w_busy_at_done, w_busy_after);
      else pass_cnt++;
   endtask

   task automatic test_restart_ignored();
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      watch1(0, 5000, 19400);
      total_cnt++;
      if (w_plots != 19200 || w_seqerr != 0 || w_gaps != 0)
         $display("FAIL restart_plots got plots=%0d seqerr=%0d gaps=%0d want 19200,0,0", w_plots, w_seqerr, w_gaps);
      else pass_cnt++;
      total_cnt++;
      if (w_dones != 1) $display("FAIL restart_done got %0d want 1", w_dones);
      else pass_cnt++;
   endtask

   task automatic test_reset_midframe();
      int cnt, noise;
      bit hit;
      cnt = 0; noise = 0; hit = 1'b0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int n = 0; n < 8100; n++) begin
         @(negedge clk);
         if (plot1) cnt++;
         if (cnt == 8000) begin
            hit = 1'b1;
            break;
         end
      end
      total_cnt++;
      if (!hit) $display("FAIL reach_8000 got %0d plots want 8000", cnt);
      else pass_cnt++;
      rst1_n = 1'b0;
      @(negedge clk);
      rst1_n = 1'b1;
      total_cnt++;
      if ({a1, x1, y1, c1, plot1, busy1, done1} !== 36'd0)
         $display("FAIL midreset_out got addr=%0d (%0d,%0d,%0d) p=%b b=%b d=%b want 0",
                  a1, x1, y1, c1, plot1, busy1, done1);
      else pass_cnt++;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (plot1 || busy1 || done1) noise++;
      end
      total_cnt++;
      if (noise != 0) $display("FAIL midreset_quiet got %0d active cycles want 0", noise);
      else pass_cnt++;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      total_cnt++;
      if (plot1 !== 1'b0) $display("FAIL new_e1_plot got %b want 0", plot1);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({plot1, x1, y1, c1} !== {1'b1, 8'd0, 7'd0, 3'd0})
         $display("FAIL new_first_pix got plot=%b (%0d,%0d,%0d) want 1 (0,0,0)", plot1, x1, y1, c1);
      else pass_cnt++;
   endtask

   task automatic test_latency2();
      int lat, idx, frame, seqerr, dones, idle;
      int plots [2];
      rst2_n = 1'b0; start2 = 1'b0;
      repeat (2) @(negedge clk);
      rst2_n = 1'b1;
      total_cnt++;
      if ({a2, plot2, busy2, done2, x2, y2, c2} !== 36'd0)
         $display("FAIL l2_reset got addr=%0d p=%b b=%b d=%b want 0", a2, plot2, busy2, done2);
      else pass_cnt++;
      start2 = 1'b1;
      @(negedge clk);
      lat = 0;
      while (!plot2 && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++;
      if (lat != 3) $display("FAIL l2_latency got %0d want 3", lat);
      else pass_cnt++;
      total_cnt++;
      if ({x2, y2, c2} !== 18'd0)
         $display("FAIL l2_first_pix got (%0d,%0d,%0d) want (0,0,0)", x2, y2, c2);
      else pass_cnt++;
      idx = 0; frame = 0; seqerr = 0; dones = 0; idle = 0;
      plots[0] = 0; plots[1] = 0;
      for (int n = 0; n < 40000 && dones < 2; n++) begin
         if (plot2) begin
            if ({x2, y2, c2} !== {8'(idx % 160), 7'(idx / 160), 3'(idx % 8)}) seqerr++;
            idx++;
            if (frame < 2) plots[frame]++;
         end
         if (done2) begin
            dones++;
            frame++;
            idx = 0;
         end
         if (!busy2 && dones == 1) idle++;
         @(negedge clk);
      end
      start2 = 1'b0;
      total_cnt++;
      if (dones != 2) $display("FAIL l2_dones got %0d want 2", dones);
      else pass_cnt++;
      total_cnt++;
      if (plots[0] != 19200 || plots[1] != 19200)
         $display("FAIL l2_plots got %0d,%0d want 19200,19200", plots[0], plots[1]);
      else pass_cnt++;
      total_cnt++;
      if (seqerr != 0) $display("FAIL l2_align got %0d bad pixels want 0", seqerr);
      else pass_cnt++;
      total_cnt++;
      if (idle != 1) $display("FAIL l2_idle_gap got %0d want 1", idle);
      else pass_cnt++;
   endtask

   initial begin
      rst1_n = 1'b0; start1 = 1'b0;
      rst2_n = 1'b0; start2 = 1'b0;
      fork
         begin
            test_reset();
            test_first_pixels();
            test_row_wrap();
            test_frame_end();
            test_restart_ignored();
            test_reset_midframe();
         end
         test_latency2();
      join
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
